step_sequencer: RTL and testbench

- Control-unit timing-step generator that sits directly upstream of the decoder.
- Produces the encoded step index T0..Tn that the decoder expands into one-hot timing signals.
- Sequences one instruction at a time through a per-instruction number of steps, with stall, halt and a start/ready handshake to the fetch logic.

---
 rtl/step_sequencer.sv | 109 ++++++++++
 tb/tb_step_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_sequencer.sv
// Timing-step generator feeding the decoder: walks T0..lim per instruction with stall/halt.
// Optional STEP_SEQ_INSTR_COUNT_EN adds a 16-bit count of completed instructions.
module step_sequencer #(
    parameter int ENCODE_WIDTH = 2,
    parameter int MAX_STEP     = 2**ENCODE_WIDTH - 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ENCODE_WIDTH-1:0] last_step,
    input  logic                    hold,
    input  logic                    halt,
    output logic [ENCODE_WIDTH-1:0] step,
    output logic                    ready,
    output logic                    busy,
    output logic                    done,
    output logic                    halted
`ifdef STEP_SEQ_INSTR_COUNT_EN
    ,
    output logic [15:0]             instr_count
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    localparam logic [ENCODE_WIDTH-1:0] MAX_L = ENCODE_WIDTH'(MAX_STEP);

    state_t                  state;
    logic [ENCODE_WIDTH-1:0] lim;
    logic                    at_last;
    logic                    finishing;

    function automatic logic [ENCODE_WIDTH-1:0] clamp_step(input logic [ENCODE_WIDTH-1:0] v);
        return (v > MAX_L) ? MAX_L : v;
    endfunction

    assign at_last   = (step == lim);
    assign finishing = (state == RUN) && !halt && !hold && at_last;
    assign ready     = !halt && ((state == IDLE) || ((state == RUN) && !hold && at_last));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            step   <= '0;
            lim    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            halted <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (halt) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else if (start) begin
                        lim   <= clamp_step(last_step);
                        step  <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (halt) begin
                        state  <= HALTED;
                        step   <= '0;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else if (hold) begin
                        state <= RUN;
                    end else if (!at_last) begin
                        step <= step + 1'b1;
                    end else begin
                        // Final step: a start on this edge chains the next instruction with no bubble.
                        done <= 1'b1;
                        step <= '0;
                        if (start) begin
                            lim <= clamp_step(last_step);
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                HALTED: begin
                    step   <= '0;
                    busy   <= 1'b0;
                    halted <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    step  <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef STEP_SEQ_INSTR_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_count <= 16'd0;
        end else if (finishing) begin
            instr_count <= instr_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench for step_sequencer: directed vector table, async-reset case, random vs model.
module tb_step_sequencer;

    localparam int EW   = 2;
    localparam int MAXS = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [EW-1:0] last_step = '0;
    logic          hold = 1'b0;
    logic          halt = 1'b0;
    logic [EW-1:0] step;
    logic          ready, busy, done, halted;
`ifdef STEP_SEQ_INSTR_COUNT_EN
    logic [15:0]   instr_count;
`endif

    step_sequencer #(.ENCODE_WIDTH(EW), .MAX_STEP(MAXS)) dut (
        .clk(clk), .rst(rst), .start(start), .last_step(last_step),
        .hold(hold), .halt(halt), .step(step), .ready(ready),
        .busy(busy), .done(done), .halted(halted)
`ifdef STEP_SEQ_INSTR_COUNT_EN
        , .instr_count(instr_count)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: the queue holds the steps still to be issued for the current instruction.
    int q[$];
    bit m_halted = 0;
    bit m_done   = 0;
    int m_count  = 0;

    function automatic void model_reset();
        q.delete();
        m_halted = 0;
        m_done   = 0;
        m_count  = 0;
    endfunction

    function automatic void model_edge(bit s, int ls, bit h, bit hl);
        bit nd = 0;
        bit acc;
        int lim;
        if (m_halted) begin
        end else if (hl) begin
            q.delete();
            m_halted = 1;
        end else if (q.size() > 0 && h) begin
        end else begin
            acc = s && (q.size() <= 1);
            if (q.size() > 0) begin
                void'(q.pop_front());
                if (q.size() == 0) nd = 1;
            end
            if (acc) begin
                lim = (ls > MAXS) ? MAXS : ls;
                for (int i = 0; i <= lim; i++) q.push_back(i);
            end
        end
        m_done = nd;
        if (nd) m_count = (m_count + 1) % 65536;
    endfunction

    function automatic int m_step();
        return (q.size() > 0) ? q[0] : 0;
    endfunction

    function automatic bit m_ready();
        return !halt && !m_halted && (q.size() == 0 || (q.size() == 1 && !hold));
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(string tag);
        check({tag, ".step"},   int'(step),   m_step());
        check({tag, ".busy"},   int'(busy),   int'(q.size() > 0));
        check({tag, ".done"},   int'(done),   int'(m_done));
        check({tag, ".ready"},  int'(ready),  int'(m_ready()));
        check({tag, ".halted"}, int'(halted), int'(m_halted));
`ifdef STEP_SEQ_INSTR_COUNT_EN
        check({tag, ".count"},  int'(instr_count), m_count);
`endif
    endtask

    // Called just after a rising edge: settle to the falling edge, optionally compare, then clock.
    task automatic tick(bit do_model_check, string tag);
        @(negedge clk);
        if (do_model_check) check_model(tag);
        @(posedge clk);
        model_edge(start, int'(last_step), hold, halt);
        #1;
    endtask

    task automatic do_reset();
        start = 0; hold = 0; halt = 0; last_step = '0;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    typedef struct {
        bit      s;
        int      ls;
        bit      h;
        bit      hl;
        int      e_step;
        bit      e_busy;
        bit      e_done;
        bit      e_ready;
        bit      e_halted;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit s, int ls, bit h, bit hl,
                                int es, bit eb, bit ed, bit er, bit eh);
        vec_t v;
        v.s = s; v.ls = ls; v.h = h; v.hl = hl;
        v.e_step = es; v.e_busy = eb; v.e_done = ed; v.e_ready = er; v.e_halted = eh;
        vecs.push_back(v);
    endfunction

    int halt_cycles;

    initial begin
        // Inputs applied for the cycle, outputs expected just before that cycle's closing edge.
        // Single instruction, last_step=3
        add(1,3,0,0, 0,0,0,1,0);
        add(0,0,0,0, 0,1,0,0,0);
        add(0,0,0,0, 1,1,0,0,0);
        add(0,0,0,0, 2,1,0,0,0);
        add(0,0,0,0, 3,1,0,1,0);
        add(0,0,0,0, 0,0,1,1,0);
        add(0,0,0,0, 0,0,0,1,0);
        // Back-to-back: last_step=1 then 2 chained at step 1
        add(1,1,0,0, 0,0,0,1,0);
        add(0,0,0,0, 0,1,0,0,0);
        add(1,2,0,0, 1,1,0,1,0);
        add(0,0,0,0, 0,1,1,0,0);
        add(0,0,0,0, 1,1,0,0,0);
        add(0,0,0,0, 2,1,0,1,0);
        add(0,0,0,0, 0,0,1,1,0);
        // Stall at step 2 for three cycles, start during hold ignored
        add(1,3,0,0, 0,0,0,1,0);
        add(0,0,0,0, 0,1,0,0,0);
        add(0,0,0,0, 1,1,0,0,0);
        add(1,0,1,0, 2,1,0,0,0);
        add(1,0,1,0, 2,1,0,0,0);
        add(0,0,1,0, 2,1,0,0,0);
        add(0,0,0,0, 2,1,0,0,0);
        add(0,0,0,0, 3,1,0,1,0);
        add(0,0,0,0, 0,0,1,1,0);
        // Single-step instruction
        add(1,0,0,0, 0,0,0,1,0);
        add(0,0,0,0, 0,1,0,1,0);
        add(0,0,0,0, 0,0,1,1,0);
        add(0,0,0,0, 0,0,0,1,0);
        // Halt at step 1, later starts ignored
        add(1,3,0,0, 0,0,0,1,0);
        add(0,0,0,0, 0,1,0,0,0);
        add(0,0,0,1, 1,1,0,0,0);
        add(1,2,0,0, 0,0,0,0,1);
        add(1,1,0,0, 0,0,0,0,1);
        add(0,0,0,0, 0,0,0,0,1);

        do_reset();
        @(negedge clk);
        check("reset.step", int'(step), 0);
        check("reset.busy", int'(busy), 0);
        check("reset.done", int'(done), 0);
        check("reset.halted", int'(halted), 0);
        check("reset.ready", int'(ready), 1);
`ifdef STEP_SEQ_INSTR_COUNT_EN
        check("reset.count", int'(instr_count), 0);
`endif
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            start = vecs[i].s; last_step = EW'(vecs[i].ls);
            hold = vecs[i].h; halt = vecs[i].hl;
            @(negedge clk);
            check($sformatf("vec%0d.step", i),   int'(step),   vecs[i].e_step);
            check($sformatf("vec%0d.busy", i),   int'(busy),   int'(vecs[i].e_busy));
            check($sformatf("vec%0d.done", i),   int'(done),   int'(vecs[i].e_done));
            check($sformatf("vec%0d.ready", i),  int'(ready),  int'(vecs[i].e_ready));
            check($sformatf("vec%0d.halted", i), int'(halted), int'(vecs[i].e_halted));
            @(posedge clk);
            model_edge(start, int'(last_step), hold, halt);
            #1;
        end
`ifdef STEP_SEQ_INSTR_COUNT_EN
        check("vec.count", int'(instr_count), 5);
`endif

        // Reset leaves HALTED
        do_reset();
        tick(1, "post_halt_reset");

        // Asynchronous reset mid-instruction at step 2
        start = 1; last_step = 2'd3;
        tick(0, "async");
        start = 0;
        tick(0, "async");
        tick(0, "async");
        check("async.pre_step", int'(step), 2);
        #2;
        rst = 1;
        #1;
        check("async.step", int'(step), 0);
        check("async.busy", int'(busy), 0);
`ifdef STEP_SEQ_INSTR_COUNT_EN
        check("async.count", int'(instr_count), 0);
`endif
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        @(negedge clk);
        check("async.done", int'(done), 0);
        check("async.ready", int'(ready), 1);
        @(posedge clk);
        #1;

        // Randomized traffic against the model
        halt_cycles = 0;
        for (int n = 0; n < 1500; n++) begin
            start     = ($urandom_range(0, 1) == 1);
            last_step = EW'($urandom_range(0, 3));
            hold      = ($urandom_range(0, 3) == 0);
            halt      = ($urandom_range(0, 79) == 0);
            tick(1, "rand");
            if (m_halted) halt_cycles++;
            if (halt_cycles > 4) begin
                halt_cycles = 0;
                do_reset();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule
